twiddle_angle_seq: RTL and testbench

TWIDDLE_ANGLE_SEQ -- requirements
Module: twiddle_angle_seq

---
 rtl/twiddle_angle_seq.sv | 113 +++++++++++
 tb/tb_twiddle_angle_seq.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/twiddle_angle_seq.sv
// rtl/twiddle_angle_seq.sv - FFT stage twiddle angle sequencer
// Streams k and the single-precision angle -2*pi*k/N for every butterfly of one stage.
module twiddle_angle_seq #(
  parameter int LOG2N = 6,
  parameter int SW    = $clog2(LOG2N + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [SW-1:0]      i_stage,
  input  logic               i_ready,
  output logic               o_valid,
  output logic [31:0]        o_angle,
  output logic [LOG2N-2:0]   o_k,
  output logic               o_last,
  output logic               o_busy,
  output logic               o_err
);

  localparam int N    = 1 << LOG2N;
  localparam int HALF = N / 2;
  localparam int KW   = LOG2N - 1;

  // Double to single, round to nearest-even; angles are normal and well inside single range.
  function automatic logic [31:0] dbl_to_sgl(input logic [63:0] d);
    logic [7:0]  e;
    logic        rnd;
    logic [30:0] mag;
    if (d[62:0] == 63'd0) return 32'h0000_0000;
    e   = 8'(d[62:52] - 11'd896);
    rnd = d[28] && ((|d[27:0]) || d[29]);
    mag = {e, d[51:29]} + 31'(rnd);
    return {d[63], mag};
  endfunction

  logic [31:0] rom [HALF];

  for (genvar g = 0; g < HALF; g++) begin : g_rom
    localparam real ANG = -6.283185307179586 * real'(g) / real'(N);
    localparam logic [31:0] ENTRY = dbl_to_sgl($realtobits(ANG));
    assign rom[g] = ENTRY;
  end

  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;

  logic [KW-1:0] m_q;
  logic          issue_done_q;
  logic [SW-1:0] shamt_q;
  logic          s1_valid_q;
  logic [KW-1:0] s1_k_q;
  logic          s1_last_q;

  logic          stage_ok, accept, issue, advance, done_xfer;
  logic [KW-1:0] k_calc;

  assign stage_ok  = (i_stage != '0) && (i_stage <= SW'(LOG2N));
  assign accept    = (state_q == IDLE) && i_start && stage_ok;
  assign issue     = (state_q == RUN) && !issue_done_q;
  assign advance   = !o_valid || i_ready;
  assign done_xfer = o_valid && i_ready && o_last;
  // Shifting m and truncating to KW bits is exactly (m mod 2^(s-1)) << (LOG2N-s).
  assign k_calc    = m_q << shamt_q;
  assign o_busy    = (state_q == RUN);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = RUN;
      RUN:     if (done_xfer) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      m_q          <= '0;
      issue_done_q <= 1'b0;
      shamt_q      <= '0;
      s1_valid_q   <= 1'b0;
      s1_k_q       <= '0;
      s1_last_q    <= 1'b0;
      o_valid      <= 1'b0;
      o_angle      <= 32'h0000_0000;
      o_k          <= '0;
      o_last       <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      state_q <= state_d;
      o_err   <= (state_q == IDLE) && i_start && !stage_ok;
      if (accept) begin
        m_q          <= '0;
        issue_done_q <= 1'b0;
        shamt_q      <= SW'(LOG2N) - i_stage;
      end else if (issue && advance) begin
        m_q <= m_q + 1'b1;
        if (m_q == KW'(HALF - 1)) issue_done_q <= 1'b1;
      end
      // Whole two-stage pipe stalls together so held outputs never change.
      if (advance) begin
        s1_valid_q <= issue;
        s1_k_q     <= k_calc;
        s1_last_q  <= issue && (m_q == KW'(HALF - 1));
        o_valid    <= s1_valid_q;
        o_k        <= s1_k_q;
        o_last     <= s1_valid_q && s1_last_q;
        o_angle    <= rom[s1_k_q];
      end
    end
  end

endmodule

// File: tb/tb_twiddle_angle_seq.sv
// tb/tb_twiddle_angle_seq.sv - self-checking bench for twiddle_angle_seq
module tb_twiddle_angle_seq;
  localparam int LOG2N = 6;
  localparam int SW    = 3;
  localparam int HALF  = 32;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_start = 1'b0;
  logic [SW-1:0] i_stage = '0;
  logic          i_ready = 1'b1;
  logic          o_valid;
  logic [31:0]   o_angle;
  logic [4:0]    o_k;
  logic          o_last;
  logic          o_busy;
  logic          o_err;

  int tests = 0;
  int fails = 0;
  int          got_k [8][32];
  logic [31:0] got_a [8][32];

  always #5 clk = ~clk;

  twiddle_angle_seq #(.LOG2N(LOG2N), .SW(SW)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_stage(i_stage),
    .i_ready(i_ready), .o_valid(o_valid), .o_angle(o_angle), .o_k(o_k),
    .o_last(o_last), .o_busy(o_busy), .o_err(o_err)
  );

  typedef struct {
    int          stage;
    int          m;
    int          k;
    logic [31:0] angle;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int model_k(input int m, input int s);
    return (m % (1 << (s - 1))) << (LOG2N - s);
  endfunction

  // Accepts a only if it is the single closest to -2*pi*k/N (error within half an ulp).
  function automatic bit angle_ok(input int k, input logic [31:0] a);
    real exact, val, p, ulp;
    int  e;
    if (k == 0) return a == 32'h0;
    exact = -2.0 * 3.141592653589793 * k / (2.0 * HALF);
    e = int'(a[30:23]);
    p = 1.0;
    if (e >= 127) for (int i = 0; i < e - 127; i++) p = p * 2.0;
    else          for (int i = 0; i < 127 - e; i++) p = p / 2.0;
    val = (1.0 + real'(a[22:0]) / 8388608.0) * p;
    ulp = p / 8388608.0;
    if (a[31]) val = -val;
    return a[31] && ((val - exact) <= ulp / 2.0) && ((exact - val) <= ulp / 2.0);
  endfunction

  task automatic run_seq(input int stage, input int pct, input int stall_m,
                         input int stall_len, input bit noise);
    int n, cyc, first, stalls;
    bit held, done;
    logic [31:0] h_a;
    logic [4:0]  h_k;
    logic        h_l;
    n = 0; cyc = 0; first = -1; stalls = 0; held = 0; done = 0;
    h_a = '0; h_k = '0; h_l = 0;
    @(negedge clk);
    i_start = 1'b1; i_stage = SW'(stage); i_ready = 1'b1;
    @(posedge clk);
    while (!done && cyc < 400) begin
      @(negedge clk);
      i_start = noise && (n < 28) && ($urandom_range(0, 1) == 1);
      i_stage = SW'($urandom_range(0, 7));
      if (stall_m >= 0 && n == stall_m && o_valid && stalls < stall_len) begin
        i_ready = 1'b0;
        stalls++;
      end else begin
        i_ready = ($urandom_range(0, 99) < pct);
      end
      chk("busy_in_run", o_busy, 1);
      chk("err_in_run", o_err, 0);
      if (held) begin
        chk("hold_valid", o_valid, 1);
        chk("hold_k", o_k, h_k);
        chk("hold_angle", o_angle, h_a);
        chk("hold_last", o_last, h_l);
      end
      if (o_valid && first < 0) first = cyc;
      if (o_valid && i_ready) begin
        chk($sformatf("k s%0d m%0d", stage, n), o_k, model_k(n, stage));
        chk($sformatf("last s%0d m%0d", stage, n), o_last, n == HALF - 1);
        tests++;
        if (!angle_ok(model_k(n, stage), o_angle)) begin
          fails++;
          $display("FAIL angle s%0d m%0d: got %h not nearest to -2pi*%0d/64", stage, n, o_angle, model_k(n, stage));
        end
        if (n < HALF) begin
          got_k[stage][n] = int'(o_k);
          got_a[stage][n] = o_angle;
        end
        n++;
        if (o_last) done = 1;
      end
      held = o_valid && !i_ready;
      h_k = o_k; h_a = o_angle; h_l = o_last;
      @(posedge clk);
      cyc++;
    end
    i_start = 1'b0;
    chk("seq_completed", done, 1);
    chk("first_valid_latency", first, 2);
    chk("transfer_count", n, HALF);
    if (stall_m >= 0) chk("stall_cycles", stalls, stall_len);
    @(negedge clk);
    chk("busy_after", o_busy, 0);
    chk("valid_after", o_valid, 0);
  endtask

  initial begin
    int cyc;
    vecs[0] = '{6, 1, 1, 32'hBDC90FDB};
    vecs[1] = '{6, 8, 8, 32'hBF490FDB};
    vecs[2] = '{6, 16, 16, 32'hBFC90FDB};
    vecs[3] = '{6, 24, 24, 32'hC016CBE4};
    vecs[4] = '{1, 0, 0, 32'h00000000};
    vecs[5] = '{1, 31, 0, 32'h00000000};
    vecs[6] = '{3, 1, 8, 32'hBF490FDB};
    vecs[7] = '{3, 4, 0, 32'h00000000};
    vecs[8] = '{3, 7, 24, 32'hC016CBE4};
    vecs[9] = '{6, 0, 0, 32'h00000000};

    i_start = 1'b1; i_stage = 3'd6;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", o_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_err", o_err, 0);
    chk("rst_last", o_last, 0);
    chk("rst_k", o_k, 0);
    chk("rst_angle", o_angle, 0);
    i_rst = 1'b0; i_start = 1'b0;

    run_seq(6, 100, -1, 0, 0);
    run_seq(1, 100, -1, 0, 0);
    run_seq(3, 100, -1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("vec%0d_k", i), got_k[vecs[i].stage][vecs[i].m], vecs[i].k);
      chk($sformatf("vec%0d_angle", i), got_a[vecs[i].stage][vecs[i].m], vecs[i].angle);
    end

    run_seq(6, 100, 5, 3, 0);

    // Reset in the middle of a stage-6 run.
    @(negedge clk);
    i_start = 1'b1; i_stage = 3'd6; i_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_start = 1'b0;
    cyc = 0;
    while (!(o_valid && o_k == 5'd10) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("reached_m10", o_valid && o_k == 5'd10, 1);
    i_rst = 1'b1; i_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_valid", o_valid, 0);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_k", o_k, 0);
    i_rst = 1'b0; i_start = 1'b0;
    got_k[6][0] = -1;
    run_seq(6, 100, -1, 0, 0);
    chk("after_rst_first_k", got_k[6][0], 0);

    // Illegal stages: one-cycle error pulse, no sequence.
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      i_start = 1'b1; i_stage = (s == 0) ? 3'd0 : 3'd7;
      @(posedge clk);
      @(negedge clk);
      i_start = 1'b0;
      chk($sformatf("ill%0d_err", s), o_err, 1);
      chk($sformatf("ill%0d_busy", s), o_busy, 0);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("ill%0d_err_drop", s), o_err, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk($sformatf("ill%0d_valid", s), o_valid, 0);
      chk($sformatf("ill%0d_busy2", s), o_busy, 0);
    end

    for (int r = 0; r < 6; r++)
      run_seq($urandom_range(1, 6), $urandom_range(30, 100), -1, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
